mem_port_arbiter: RTL and testbench

Shares the single synchronous port of the external program/data memory between three requesters: the data path (load/store), the instruction fetch path and the human-interface debug reader. It selects one requester per cycle, drives the memory address/write lines and routes returned read data back to the requester that issued the read. Its stall output gates the control unit's register-bank enable while a fetch is waiting.

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single synchronous memory port shared by the data path, instruction
// fetch and debug reader; tracks read ownership so returned data reaches its issuer.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_gnt,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic                  boost
);

  localparam logic [1:0] ID_DATA  = 2'd0;
  localparam logic [1:0] ID_FETCH = 2'd1;
  localparam logic [1:0] ID_DBG   = 2'd2;
  localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

  logic                   active;
  logic [7:0]             starve_cnt;
  logic [7:0]             starve_cnt_nxt;
  logic                   boost_nxt;
  logic                   issue_valid;
  logic [1:0]             issue_id;
  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [1:0]             pipe_id [MEM_LATENCY];
  logic                   tail_valid;
  logic [1:0]             tail_id;

  // Grants stay low until the first clock edge after reset release, so release is synchronous.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) active <= 1'b0;
    else        active <= 1'b1;
  end

  always_comb begin
    data_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    dbg_gnt   = 1'b0;
    if (active) begin
      if (boost && dbg_req) dbg_gnt   = 1'b1;
      else if (data_req)    data_gnt  = 1'b1;
      else if (fetch_req)   fetch_gnt = 1'b1;
      else if (dbg_req)     dbg_gnt   = 1'b1;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (data_gnt)       mem_addr = data_addr;
    else if (fetch_gnt) mem_addr = fetch_addr;
    else if (dbg_gnt)   mem_addr = dbg_addr;
  end

  assign mem_we    = data_gnt & data_we;
  assign mem_wdata = mem_we ? data_wdata : '0;
  assign stall     = active & fetch_req & ~fetch_gnt;

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!active || !dbg_req || dbg_gnt) starve_cnt_nxt = 8'd0;
    else if (starve_cnt != 8'hFF)       starve_cnt_nxt = starve_cnt + 8'd1;
  end

  always_comb begin
    boost_nxt = boost;
    if (dbg_gnt)                                          boost_nxt = 1'b0;
    else if (active && dbg_req && starve_cnt_nxt == LIMIT) boost_nxt = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= 8'd0;
      boost      <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      boost      <= boost_nxt;
    end
  end

  // Writes and idle cycles enter the owner pipeline as bubbles so return order matches issue order.
  always_comb begin
    issue_valid = 1'b0;
    issue_id    = ID_DATA;
    if (data_gnt && !data_we) begin
      issue_valid = 1'b1;
      issue_id    = ID_DATA;
    end else if (fetch_gnt) begin
      issue_valid = 1'b1;
      issue_id    = ID_FETCH;
    end else if (dbg_gnt) begin
      issue_valid = 1'b1;
      issue_id    = ID_DBG;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe_id[i] <= ID_DATA;
    end else begin
      pipe_valid[0] <= issue_valid;
      pipe_id[0]    <= issue_id;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign tail_valid = pipe_valid[MEM_LATENCY-1];
  assign tail_id    = pipe_id[MEM_LATENCY-1];

  assign data_rvalid  = tail_valid && (tail_id == ID_DATA);
  assign fetch_rvalid = tail_valid && (tail_id == ID_FETCH);
  assign dbg_rvalid   = tail_valid && (tail_id == ID_DBG);

  assign data_rdata  = data_rvalid  ? mem_rdata : '0;
  assign fetch_rdata = fetch_rvalid ? mem_rdata : '0;
  assign dbg_rdata   = dbg_rvalid   ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share stimulus; read
// returns are checked by a monitor against a per-instance expectation queue.
module tb_mem_port_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          data_req, data_we, fetch_req, dbg_req;
  logic [AW-1:0] data_addr, fetch_addr, dbg_addr;
  logic [DW-1:0] data_wdata;

  logic [1:0]    data_gnt, data_rvalid, fetch_gnt, fetch_rvalid, dbg_gnt, dbg_rvalid;
  logic [1:0]    mem_we, stall, boost;
  logic [DW-1:0] data_rdata [2];
  logic [DW-1:0] fetch_rdata [2];
  logic [DW-1:0] dbg_rdata [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];
  logic [AW-1:0] mem_addr [2];

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .STARVE_LIMIT(8)) u_lat1 (
    .clock(clock), .reset(reset),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt[0]), .data_rvalid(data_rvalid[0]), .data_rdata(data_rdata[0]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt[0]), .fetch_rvalid(fetch_rvalid[0]), .fetch_rdata(fetch_rdata[0]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt[0]), .dbg_rvalid(dbg_rvalid[0]), .dbg_rdata(dbg_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_we(mem_we[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .stall(stall[0]), .boost(boost[0])
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3), .STARVE_LIMIT(8)) u_lat3 (
    .clock(clock), .reset(reset),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt[1]), .data_rvalid(data_rvalid[1]), .data_rdata(data_rdata[1]),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt[1]), .fetch_rvalid(fetch_rvalid[1]), .fetch_rdata(fetch_rdata[1]),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt[1]), .dbg_rvalid(dbg_rvalid[1]), .dbg_rdata(dbg_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_we(mem_we[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .stall(stall[1]), .boost(boost[1])
  );

  // Memory stand-in: word at address a is 0xE000_0000 | (a ^ 0x1224), returned after the latency.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hE000_0000 | {18'h0, a ^ 14'h1224};
  endfunction

  logic [AW-1:0] a1;
  logic [AW-1:0] a3 [3];
  always @(posedge clock) begin
    a1    <= mem_addr[0];
    a3[0] <= mem_addr[1];
    a3[1] <= a3[0];
    a3[2] <= a3[1];
  end
  assign mem_rdata[0] = mem_word(a1);
  assign mem_rdata[1] = mem_word(a3[2]);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected read returns, one ring per instance: owner id, due cycle, data.
  logic [1:0]  exp_id  [2][64];
  int          exp_due [2][64];
  logic [31:0] exp_dat [2][64];
  int          wr_ptr [2];
  int          rd_ptr [2];

  task automatic push(input int k, input logic [1:0] id, input logic [31:0] dat, input int lat);
    exp_id[k][wr_ptr[k] % 64]  = id;
    exp_due[k][wr_ptr[k] % 64] = cyc + lat;
    exp_dat[k][wr_ptr[k] % 64] = dat;
    wr_ptr[k]++;
  endtask

  task automatic push_read(input logic [1:0] id, input logic [31:0] dat);
    push(0, id, dat, 1);
    push(1, id, dat, 3);
  endtask

  initial begin : monitor
    logic [2:0]  rv;
    logic [1:0]  gid;
    logic [31:0] got;
    int          idx;
    forever begin
      @(negedge clock);
      #2;
      for (int k = 0; k < 2; k++) begin
        rv  = {dbg_rvalid[k], fetch_rvalid[k], data_rvalid[k]};
        got = data_rdata[k] | fetch_rdata[k] | dbg_rdata[k];
        idx = rd_ptr[k] % 64;
        if (rv != 3'b000) begin
          gid = (rv == 3'b001) ? 2'd0 : (rv == 3'b010) ? 2'd1 : (rv == 3'b100) ? 2'd2 : 2'd3;
          if (rd_ptr[k] == wr_ptr[k]) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected dut%0d: got rvalid %b expected none (cycle %0d)", k, rv, cyc);
          end else begin
            chk($sformatf("rvalid_owner dut%0d", k), {30'h0, gid}, {30'h0, exp_id[k][idx]});
            chk($sformatf("rvalid_cycle dut%0d", k), cyc, exp_due[k][idx]);
            chk($sformatf("rdata dut%0d", k), got, exp_dat[k][idx]);
            rd_ptr[k]++;
          end
        end else begin
          if (got != 32'h0) begin
            checks++;
            errors++;
            $display("FAIL rdata_idle dut%0d: got %h expected 0 (cycle %0d)", k, got, cyc);
          end
          if (rd_ptr[k] != wr_ptr[k] && exp_due[k][idx] <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rvalid_missing dut%0d: got none expected owner %0d (cycle %0d)",
                     k, exp_id[k][idx], cyc);
            rd_ptr[k]++;
          end
        end
      end
    end
  end

  task automatic drive(input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                       input logic fr, input logic [AW-1:0] fa, input logic br, input logic [AW-1:0] ba);
    @(negedge clock);
    data_req   = dr;
    data_we    = dw;
    data_addr  = da;
    data_wdata = dwd;
    fetch_req  = fr;
    fetch_addr = fa;
    dbg_req    = br;
    dbg_addr   = ba;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  // exp_gnt is {dbg, fetch, data}.
  task automatic chk_gnt(input string tag, input logic [2:0] exp_gnt, input logic [AW-1:0] exp_addr,
                         input logic exp_stall, input logic exp_boost);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s gnt dut%0d", tag, k), {29'h0, dbg_gnt[k], fetch_gnt[k], data_gnt[k]}, {29'h0, exp_gnt});
      chk($sformatf("%s mem_addr dut%0d", tag, k), {18'h0, mem_addr[k]}, {18'h0, exp_addr});
      chk($sformatf("%s stall dut%0d", tag, k), {31'h0, stall[k]}, {31'h0, exp_stall});
      chk($sformatf("%s boost dut%0d", tag, k), {31'h0, boost[k]}, {31'h0, exp_boost});
    end
  endtask

  task automatic chk_write(input string tag, input logic exp_we, input logic [DW-1:0] exp_wdata);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s mem_we dut%0d", tag, k), {31'h0, mem_we[k]}, {31'h0, exp_we});
      chk($sformatf("%s mem_wdata dut%0d", tag, k), mem_wdata[k], exp_wdata);
    end
  endtask

  initial begin
    wr_ptr = '{0, 0};
    rd_ptr = '{0, 0};
    reset      = 1'b0;
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 14'h0111;
    data_wdata = 32'hA5A5_A5A5;
    fetch_req  = 1'b1;
    fetch_addr = 14'h0222;
    dbg_req    = 1'b1;
    dbg_addr   = 14'h0333;

    repeat (3) @(negedge clock);
    #1;
    chk_gnt("reset", 3'b000, 14'h0, 1'b0, 1'b0);
    chk_write("reset", 1'b0, 32'h0);
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset rvalid dut%0d", k),
          {29'h0, dbg_rvalid[k], fetch_rvalid[k], data_rvalid[k]}, 32'h0);

    @(negedge clock);
    reset    = 1'b1;
    data_req = 1'b0;
    data_we  = 1'b0;
    fetch_req = 1'b0;
    dbg_req  = 1'b0;

    drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h0010, 1'b0, '0);
    chk_gnt("fetch_first", 3'b010, 14'h0010, 1'b0, 1'b0);
    push_read(2'd1, 32'hE000_1234);

    drive(1'b1, 1'b0, 14'h0200, '0, 1'b1, 14'h0011, 1'b0, '0);
    chk_gnt("contend_data", 3'b001, 14'h0200, 1'b1, 1'b0);
    push_read(2'd0, 32'hE000_1024);

    drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h0011, 1'b0, '0);
    chk_gnt("contend_fetch", 3'b010, 14'h0011, 1'b0, 1'b0);
    push_read(2'd1, 32'hE000_1235);

    drive(1'b1, 1'b1, 14'h0300, 32'hDEAD_BEEF, 1'b0, '0, 1'b0, '0);
    chk_gnt("write", 3'b001, 14'h0300, 1'b0, 1'b0);
    chk_write("write", 1'b1, 32'hDEAD_BEEF);

    idle();
    chk_gnt("idle", 3'b000, 14'h0, 1'b0, 1'b0);
    chk_write("idle", 1'b0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 14'h0040, '0, 1'b1, 14'h0041, 1'b1, 14'h0005);
      chk_gnt($sformatf("starve_wait%0d", i), 3'b001, 14'h0040, 1'b1, 1'b0);
      push_read(2'd0, 32'hE000_1264);
    end
    drive(1'b1, 1'b0, 14'h0040, '0, 1'b1, 14'h0041, 1'b1, 14'h0005);
    chk_gnt("boost_dbg", 3'b100, 14'h0005, 1'b1, 1'b1);
    push_read(2'd2, 32'hE000_1221);

    drive(1'b1, 1'b0, 14'h0040, '0, 1'b1, 14'h0041, 1'b0, '0);
    chk_gnt("boost_clear", 3'b001, 14'h0040, 1'b1, 1'b0);
    push_read(2'd0, 32'hE000_1264);

    drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h0020, 1'b0, '0);
    chk_gnt("b2b_fetch", 3'b010, 14'h0020, 1'b0, 1'b0);
    push_read(2'd1, 32'hE000_1204);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 14'h0030);
    chk_gnt("b2b_dbg", 3'b100, 14'h0030, 1'b0, 1'b0);
    push_read(2'd2, 32'hE000_1214);
    drive(1'b1, 1'b0, 14'h0050, '0, 1'b0, '0, 1'b0, '0);
    chk_gnt("b2b_data", 3'b001, 14'h0050, 1'b0, 1'b0);
    push_read(2'd0, 32'hE000_1274);

    drive(1'b1, 1'b0, 14'h0060, '0, 1'b0, '0, 1'b1, 14'h0061);
    chk_gnt("drop_pre", 3'b001, 14'h0060, 1'b0, 1'b0);
    push_read(2'd0, 32'hE000_1244);
    idle();
    chk_gnt("drop_after", 3'b000, 14'h0, 1'b0, 1'b0);

    repeat (4) idle();

    drive(1'b0, 1'b0, '0, '0, 1'b1, 14'h0070, 1'b0, '0);
    chk_gnt("midflight", 3'b010, 14'h0070, 1'b0, 1'b0);
    push(0, 2'd1, 32'hE000_1254, 1);
    idle();
    #2;
    reset = 1'b0;
    #1;
    chk("midflight rvalid dut1", {29'h0, dbg_rvalid[1], fetch_rvalid[1], data_rvalid[1]}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (6) idle();
    chk_gnt("post_reset", 3'b000, 14'h0, 1'b0, 1'b0);

    for (int k = 0; k < 2; k++)
      chk($sformatf("drain dut%0d", k), rd_ptr[k], wr_ptr[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
